// File: rtl/call_arbiter_pkg.sv
// Shared types and constants for the helper-call arbiter and its round-robin picker.
package call_arbiter_pkg;

  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [63:0] HELPER_LED   = 64'hff000001;
  localparam logic [63:0] HELPER_STORE = 64'hff000002;
  localparam logic [63:0] HELPER_LOAD  = 64'hff000003;

endpackage

// File: rtl/call_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_cand;

  // Scan from farthest to nearest so the nearest set bit is written last and wins.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = N; k >= 1; k--) begin
      w_cand = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_cand]) o_idx = w_cand;
    end
  end

endmodule

// File: rtl/call_arbiter.sv
// Shares one helper-call handler among N_REQ cores: round-robin grant, argument latch,
// strobe-until-ack handshake, result routing and hung-call timeout.
module call_arbiter
  import call_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10,
  localparam int GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_stb,
  input  logic [N_REQ*DATA_W-1:0] req_func,
  input  logic [N_REQ*DATA_W-1:0] req_r1,
  input  logic [N_REQ*DATA_W-1:0] req_r2,
  input  logic [N_REQ*DATA_W-1:0] req_r3,
  input  logic [N_REQ*DATA_W-1:0] req_r4,
  input  logic [N_REQ*DATA_W-1:0] req_r5,
  output logic [N_REQ-1:0]        req_ack,
  output logic [N_REQ-1:0]        req_err,
  output logic [DATA_W-1:0]       req_ret,
  output logic [DATA_W-1:0]       dn_func,
  output logic [DATA_W-1:0]       dn_r1,
  output logic [DATA_W-1:0]       dn_r2,
  output logic [DATA_W-1:0]       dn_r3,
  output logic [DATA_W-1:0]       dn_r4,
  output logic [DATA_W-1:0]       dn_r5,
  output logic                    dn_stb,
  input  logic [DATA_W-1:0]       dn_ret,
  input  logic                    dn_ack,
  input  logic                    dn_err,
  output logic                    busy,
  output logic [GW-1:0]           grant_id,
  output logic                    timeout_pulse
);

  localparam int NARG = 6;

  state_t                                 r_state, w_next;
  logic [GW-1:0]                          r_rr_ptr, r_grant_id;
  logic [TO_W-1:0]                        r_timer;
  logic [NARG-1:0][DATA_W-1:0]            r_dn;
  logic [N_REQ-1:0]                       r_req_ack, r_req_err;
  logic [DATA_W-1:0]                      r_req_ret;
  logic                                   r_to_pulse;
  logic [N_REQ-1:0][NARG-1:0][DATA_W-1:0] w_args;
  logic                                   w_pick_vld, w_grant, w_done, w_tout;
  logic [GW-1:0]                          w_pick_idx;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_args[i] = {req_r5[i*DATA_W +: DATA_W], req_r4[i*DATA_W +: DATA_W],
                        req_r3[i*DATA_W +: DATA_W], req_r2[i*DATA_W +: DATA_W],
                        req_r1[i*DATA_W +: DATA_W], req_func[i*DATA_W +: DATA_W]};
  end

  rr_pick #(.N(N_REQ), .IW(GW)) u_pick (
    .i_req   (req_stb),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_vld),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_done  = 1'b0;
    w_tout  = 1'b0;
    case (r_state)
      ST_IDLE: if (w_pick_vld) begin
        w_next  = ST_ISSUE;
        w_grant = 1'b1;
      end
      // An ack on the last allowed cycle beats the timeout.
      ST_ISSUE: if (dn_ack) begin
        w_next = ST_GAP;
        w_done = 1'b1;
      end else if (r_timer == TO_W'(TIMEOUT - 1)) begin
        w_next = ST_GAP;
        w_done = 1'b1;
        w_tout = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= GW'(N_REQ - 1);
      r_grant_id <= '0;
      r_timer    <= '0;
      r_dn       <= '0;
      r_req_ack  <= '0;
      r_req_err  <= '0;
      r_req_ret  <= '0;
      r_to_pulse <= 1'b0;
    end else begin
      r_req_ack  <= '0;
      r_req_err  <= '0;
      r_to_pulse <= 1'b0;
      if (r_state == ST_ISSUE) r_timer <= r_timer + 1'b1;
      if (w_grant) begin
        r_dn       <= w_args[w_pick_idx];
        r_grant_id <= w_pick_idx;
        r_rr_ptr   <= w_pick_idx;
        r_timer    <= '0;
      end
      if (w_done) begin
        r_req_ack[r_grant_id] <= 1'b1;
        r_req_err[r_grant_id] <= w_tout | dn_err;
        r_req_ret             <= w_tout ? '0 : dn_ret;
        r_to_pulse            <= w_tout;
      end
    end
  end

  // Strobe falls in the ack cycle so the handler never re-samples the same call.
  assign dn_stb        = (r_state == ST_ISSUE) & ~dn_ack;
  assign busy          = (r_state != ST_IDLE);
  assign grant_id      = r_grant_id;
  assign req_ack       = r_req_ack;
  assign req_err       = r_req_err;
  assign req_ret       = r_req_ret;
  assign timeout_pulse = r_to_pulse;
  assign dn_func       = r_dn[0];
  assign dn_r1         = r_dn[1];
  assign dn_r2         = r_dn[2];
  assign dn_r3         = r_dn[3];
  assign dn_r4         = r_dn[4];
  assign dn_r5         = r_dn[5];

endmodule

// File: tb/tb_call_arbiter.sv
// Randomized bench for call_arbiter: stub handler, requester drivers and a call-level reference model.
module tb_call_arbiter;
  import call_arbiter_pkg::*;

  localparam int N = 4, W = 64, TMO = 8, TW = 4, GW = 2;

  logic clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0] req_stb, req_ack, req_err;
  logic [N*W-1:0] req_func, req_r1, req_r2, req_r3, req_r4, req_r5;
  logic [W-1:0] req_ret, dn_func, dn_r1, dn_r2, dn_r3, dn_r4, dn_r5, dn_ret;
  logic dn_stb, dn_ack, dn_err, busy, timeout_pulse;
  logic [GW-1:0] grant_id;

  call_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TMO), .TO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .req_stb(req_stb), .req_func(req_func),
    .req_r1(req_r1), .req_r2(req_r2), .req_r3(req_r3), .req_r4(req_r4), .req_r5(req_r5),
    .req_ack(req_ack), .req_err(req_err), .req_ret(req_ret),
    .dn_func(dn_func), .dn_r1(dn_r1), .dn_r2(dn_r2), .dn_r3(dn_r3), .dn_r4(dn_r4), .dn_r5(dn_r5),
    .dn_stb(dn_stb), .dn_ret(dn_ret), .dn_ack(dn_ack), .dn_err(dn_err),
    .busy(busy), .grant_id(grant_id), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- stub call handler: accepts on a sampled strobe, acks d cycles later
  int h_mode = 1;   // 0 random delay / hang, 1 fixed delay 2, 2 never ack
  bit h_wait = 0;
  int h_cnt = 0;
  logic stb_s;
  logic [W-1:0] mem [8];

  function automatic int pick_d();
    int r;
    if (h_mode == 2) return 1000;
    if (h_mode == 1) return 2;
    r = $urandom_range(0, 7);
    if (r == 0) return 1000;
    if (r == 1) return TMO - 1;
    return $urandom_range(1, 3);
  endfunction

  initial begin
    dn_ack = 0; dn_err = 0; dn_ret = '0;
    foreach (mem[i]) mem[i] = '0;
    forever begin
      @(negedge clk); stb_s = dn_stb;
      @(posedge clk); #1;
      dn_ack = 0; dn_err = 0;
      if (!rst_n) h_wait = 0;
      else begin
        if (!h_wait && stb_s) begin h_wait = 1; h_cnt = pick_d(); end
        if (h_wait) begin
          if (!stb_s) h_wait = 0;
          else if (h_cnt == 1) begin
            h_wait = 0; dn_ack = 1;
            case (dn_func)
              HELPER_LED:   dn_ret = '0;
              HELPER_STORE: begin mem[dn_r1[2:0]] = dn_r2; dn_ret = '0; end
              HELPER_LOAD:  dn_ret = mem[dn_r1[2:0]];
              default:      begin dn_err = 1; dn_ret = {$urandom, $urandom}; end
            endcase
          end else h_cnt--;
        end
      end
    end
  end

  // ---------------- reference model: idle / issuing / gap, counted in ISSUE cycles
  function automatic int rr_next(input logic [N-1:0] pend, input int from);
    for (int k = 1; k <= N; k++) if (pend[(from + k) % N]) return (from + k) % N;
    return from;
  endfunction

  int ph = 0, cnt = 0, last = N - 1;
  logic [GW-1:0] gexp = '0;
  logic [W-1:0] eret = '0, p_ret = '0;
  bit e_err = 0, e_to = 0;
  logic [N-1:0] p_pend = '0, acked = '0;
  logic p_ack = 0, p_err = 0;
  logic [N*W-1:0] p_a [6];
  logic [W-1:0] ea [6];

  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 0; cnt = 0; last = N - 1; gexp = '0; eret = '0; acked = '0;
    end else begin
      case (ph)
        0: if (p_pend != '0) begin
          last = rr_next(p_pend, last); gexp = GW'(last); ph = 1; cnt = 1;
          for (int k = 0; k < 6; k++) ea[k] = p_a[k][last*W +: W];
        end
        1: if (p_ack) begin ph = 2; e_err = p_err; e_to = 0; eret = p_ret; end
           else if (cnt == TMO) begin ph = 2; e_err = 1; e_to = 1; eret = '0; end
           else cnt++;
        default: ph = 0;
      endcase
      chk("busy", busy, ph != 0);
      chk("dn_stb", dn_stb, (ph == 1) && !dn_ack);
      chk("req_ack", req_ack, (ph == 2) ? (4'b1 << last) : 4'b0);
      chk("req_err", req_err, (ph == 2 && e_err) ? (4'b1 << last) : 4'b0);
      chk("req_ret", req_ret, eret);
      chk("tmo_pulse", timeout_pulse, (ph == 2) && e_to);
      chk("grant_id", grant_id, gexp);
      if (ph == 1) begin
        chk("dn_func", dn_func, ea[0]); chk("dn_r1", dn_r1, ea[1]); chk("dn_r2", dn_r2, ea[2]);
        chk("dn_r3", dn_r3, ea[3]); chk("dn_r4", dn_r4, ea[4]); chk("dn_r5", dn_r5, ea[5]);
      end
      if (ph == 0) begin chk("proto_stb_after_ack", req_stb & acked, '0); acked = '0; end
      if (ph == 2) acked = 4'b1 << last;
    end
    p_pend = rst_n ? req_stb : '0;
    p_ack = rst_n & dn_ack; p_err = dn_err; p_ret = dn_ret;
    p_a[0] = req_func; p_a[1] = req_r1; p_a[2] = req_r2;
    p_a[3] = req_r3; p_a[4] = req_r4; p_a[5] = req_r5;
  end

  // ---------------- requester drivers
  int cool[N];
  int order[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] f, input logic [W-1:0] a1, input logic [W-1:0] a2);
    req_func[i*W +: W] = f; req_r1[i*W +: W] = a1; req_r2[i*W +: W] = a2;
    req_r3[i*W +: W] = {$urandom, $urandom}; req_r4[i*W +: W] = {$urandom, $urandom};
    req_r5[i*W +: W] = {$urandom, $urandom};
    req_stb[i] = 1'b1;
  endtask

  function automatic logic [W-1:0] rand_func();
    case ($urandom_range(0, 3))
      0: return HELPER_LED;
      1: return HELPER_STORE;
      2: return HELPER_LOAD;
      default: return {32'h0, $urandom};
    endcase
  endfunction

  task automatic call(input int i, input logic [W-1:0] f, input logic [W-1:0] a1, input logic [W-1:0] a2,
                      output logic [W-1:0] ret, output bit err, output int lat,
                      output logic [N-1:0] ackv, output logic tp);
    bit got = 0;
    set_req(i, f, a1, a2);
    lat = 0; ret = '0; err = 0; ackv = '0; tp = 0;
    while (!got && lat < 40) begin
      tick(); lat++;
      if (req_ack[i]) begin
        got = 1; ret = req_ret; err = req_err[i]; ackv = req_ack; tp = timeout_pulse;
        req_stb[i] = 1'b0;
      end
    end
    if (!got) chk("call_wait", 0, 1);
    tick(); tick();
  endtask

  task automatic drive_cycle(input int raise_pct, input bit chaos);
    tick();
    for (int i = 0; i < N; i++) begin
      if (req_stb[i] && req_ack[i]) begin
        order.push_back(i); req_stb[i] = 1'b0; cool[i] = 2;
      end else if (!req_stb[i]) begin
        if (cool[i] > 0) cool[i]--;
        else if ($urandom_range(0, 99) < raise_pct)
          set_req(i, rand_func(), W'($urandom_range(0, 7)), {$urandom, $urandom});
      end else if (chaos) begin
        if (busy && grant_id == GW'(i)) begin
          if ($urandom_range(0, 3) == 0) set_req(i, rand_func(), {$urandom, $urandom}, {$urandom, $urandom});
        end else if ($urandom_range(0, 49) == 0) req_stb[i] = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ret;
    bit err;
    int lat, n;
    logic [N-1:0] ackv;
    logic tp;
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    req_stb = '0; req_func = '0; req_r1 = '0; req_r2 = '0; req_r3 = '0; req_r4 = '0; req_r5 = '0;
    foreach (cool[i]) cool[i] = 0;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_dn_stb", dn_stb, 0); chk("rst_req_ack", req_ack, 0);
    chk("rst_req_err", req_err, 0); chk("rst_req_ret", req_ret, 0); chk("rst_grant_id", grant_id, 0);
    chk("rst_tmo", timeout_pulse, 0); chk("rst_dn_func", dn_func, 0); chk("rst_dn_r1", dn_r1, 0);
    chk("rst_dn_r5", dn_r5, 0);
    rst_n = 1; tick();

    h_mode = 1;
    call(0, HELPER_LED, 3, 0, ret, err, lat, ackv, tp);
    chk("led_err", err, 0); chk("led_lat", lat, 4); chk("led_ackv", ackv, 4'b0001);
    call(1, HELPER_STORE, 5, 64'hDEAD, ret, err, lat, ackv, tp);
    chk("store_err", err, 0);
    call(1, HELPER_LOAD, 5, 0, ret, err, lat, ackv, tp);
    chk("load_ret", ret, 64'hDEAD); chk("load_err", err, 0);
    call(2, 64'h1234, 0, 0, ret, err, lat, ackv, tp);
    chk("unk_err", err, 1); chk("unk_ackv", ackv, 4'b0100);

    h_mode = 2;
    call(3, HELPER_STORE, 1, 2, ret, err, lat, ackv, tp);
    chk("to_err", err, 1); chk("to_ret", ret, 0); chk("to_lat", lat, 1 + TMO); chk("to_pulse", tp, 1);
    h_mode = 1;
    call(0, HELPER_LED, 1, 0, ret, err, lat, ackv, tp);
    chk("post_to_err", err, 0); chk("post_to_lat", lat, 4);

    // reset while a call is hanging in ISSUE
    h_mode = 2;
    set_req(2, HELPER_STORE, 7, 64'hBEEF);
    n = 0;
    while (!(busy && dn_stb) && n < 20) begin tick(); n++; end
    chk("rs_in_issue", busy && dn_stb, 1);
    tick(); #2 rst_n = 0; #1;
    chk("rs_dn_stb", dn_stb, 0); chk("rs_busy", busy, 0); chk("rs_req_ack", req_ack, 0);
    req_stb = '0;
    tick(); tick(); rst_n = 1; h_mode = 1;
    tick(); chk("rs_no_ack", req_ack, 0);

    // all cores contend after reset: core 0 first, strict rotation
    for (int i = 0; i < N; i++) set_req(i, HELPER_LED, W'(i), 0);
    order.delete(); n = 0;
    while (order.size() < 5 && n < 100) begin drive_cycle(100, 0); n++; end
    chk("fair_count", order.size(), 5);
    for (int k = 0; k < 5 && k < order.size(); k++) chk($sformatf("fair_order%0d", k), order[k], exp_ord[k]);

    h_mode = 0;
    repeat (3000) drive_cycle(30, 1);
    n = 0;
    while ((req_stb != '0 || busy) && n < 300) begin drive_cycle(0, 0); n++; end
    chk("drain", (req_stb == '0) && !busy, 1);
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
